// File: rtl/vector_ex_mem_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_ex_mem_buffer_if
// Purpose  : Bundles the signals between the execute stage, the EX/MEM buffer
//            and the memory stage.
// Ports    : execute side - flush, in_valid, in_ready, alu_result, store_data,
//                           rd, reg_write, mem_write, mem_read
//            memory side  - out_valid, out_ready, out_result, out_store_data,
//                           out_rd, out_reg_write, out_mem_write, out_mem_read,
//                           out_zero_mask
//            status       - occupancy, retired_count
// Modports : slave  - the buffer itself
//            master - the environment driving and consuming the buffer
// Revision : 1.0 - initial release
// ============================================================================
interface vector_ex_mem_buffer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int LANES          = 6,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH*LANES-1:0] alu_result;
    logic [DATA_WIDTH*LANES-1:0] store_data;
    logic [REG_ADDR_WIDTH-1:0]   rd;
    logic                        reg_write;
    logic                        mem_write;
    logic                        mem_read;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*LANES-1:0] out_result;
    logic [DATA_WIDTH*LANES-1:0] out_store_data;
    logic [REG_ADDR_WIDTH-1:0]   out_rd;
    logic                        out_reg_write;
    logic                        out_mem_write;
    logic                        out_mem_read;
    logic [LANES-1:0]            out_zero_mask;
    logic [1:0]                  occupancy;
    logic [15:0]                 retired_count;

    modport slave (
        input  flush, in_valid, alu_result, store_data, rd,
               reg_write, mem_write, mem_read, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_write, out_mem_read, out_zero_mask,
               occupancy, retired_count
    );

    modport master (
        output flush, in_valid, alu_result, store_data, rd,
               reg_write, mem_write, mem_read, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_write, out_mem_read, out_zero_mask,
               occupancy, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/vector_ex_mem_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vector_ex_mem_buffer
// Purpose  : EX/MEM pipeline buffer behind the vector ALU. A 2-entry
//            ready/valid skid FIFO holding the packed result, store data,
//            destination, memory control bits and a per-lane zero mask.
// Ports    : clk  - clock, all state updates on rising edge
//            rst  - synchronous, active-low reset
//            bus  - vector_ex_mem_buffer_if.slave (handshake, data, status)
// Revision : 1.0 - initial release
// ============================================================================
module vector_ex_mem_buffer #(
    parameter int DATA_WIDTH     = 8,
    parameter int LANES          = 6,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    vector_ex_mem_buffer_if.slave       bus
);
    localparam int c_VEC_W = DATA_WIDTH * LANES;

    // Entry storage, indexed by the 1-bit head/tail pointers
    logic [1:0][c_VEC_W-1:0]        r_result;
    logic [1:0][c_VEC_W-1:0]        r_storeData;
    logic [1:0][REG_ADDR_WIDTH-1:0] r_rd;
    logic [1:0]                     r_regWrite;
    logic [1:0]                     r_memWrite;
    logic [1:0]                     r_memRead;
    logic [1:0][LANES-1:0]          r_zeroMask;

    logic                           r_head;
    logic                           r_tail;
    logic [1:0]                     r_count;
    logic [15:0]                    r_retired;

    logic [LANES-1:0]               w_zeroMask;
    logic                           w_inReady;
    logic                           w_outValid;
    logic                           w_push;
    logic                           w_pop;

    // Zero detection happens on the incoming result so the memory stage
    // sees a ready-made registered mask.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_zero
        assign w_zeroMask[gi] = (bus.alu_result[gi*DATA_WIDTH +: DATA_WIDTH] == '0);
    end

    // in_ready depends only on registered occupancy (and reset), never on
    // out_ready, so memory-stage stalls do not ripple back combinationally.
    assign w_inReady  = rst & (r_count != 2'd2);
    assign w_outValid = (r_count != 2'd0);
    assign w_push     = bus.in_valid & w_inReady & ~bus.flush;
    assign w_pop      = w_outValid & bus.out_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result    <= '0;
            r_storeData <= '0;
            r_rd        <= '0;
            r_regWrite  <= '0;
            r_memWrite  <= '0;
            r_memRead   <= '0;
            r_zeroMask  <= '0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_count     <= 2'd0;
            r_retired   <= 16'd0;
        end else if (bus.flush) begin
            // Entry payloads are left in place; output gating hides them.
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_result[r_tail]    <= bus.alu_result;
                r_storeData[r_tail] <= bus.store_data;
                r_rd[r_tail]        <= bus.rd;
                r_regWrite[r_tail]  <= bus.reg_write;
                r_memWrite[r_tail]  <= bus.mem_write;
                r_memRead[r_tail]   <= bus.mem_read;
                r_zeroMask[r_tail]  <= w_zeroMask;
                r_tail              <= ~r_tail;
            end
            if (w_pop) begin
                r_head    <= ~r_head;
                r_retired <= r_retired + 16'd1;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Every head field is forced to zero while no entry is valid, so stale
    // payload can never show up as a phantom register or memory write.
    assign bus.in_ready       = w_inReady;
    assign bus.out_valid      = w_outValid;
    assign bus.out_result     = w_outValid ? r_result[r_head]    : '0;
    assign bus.out_store_data = w_outValid ? r_storeData[r_head] : '0;
    assign bus.out_rd         = w_outValid ? r_rd[r_head]        : '0;
    assign bus.out_reg_write  = w_outValid & r_regWrite[r_head];
    assign bus.out_mem_write  = w_outValid & r_memWrite[r_head];
    assign bus.out_mem_read   = w_outValid & r_memRead[r_head];
    assign bus.out_zero_mask  = w_outValid ? r_zeroMask[r_head]  : '0;
    assign bus.occupancy      = r_count;
    assign bus.retired_count  = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_vector_ex_mem_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_ex_mem_buffer
// Purpose  : Self-checking bench for vector_ex_mem_buffer. A queue-based
//            reference model tracks accepted entries; a monitor compares the
//            DUT outputs against it every cycle; directed sequences add
//            explicit checks for the listed scenarios.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_ex_mem_buffer;
    localparam int DATA_WIDTH     = 8;
    localparam int LANES          = 6;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int c_VEC_W        = DATA_WIDTH * LANES;

    typedef struct {
        logic [c_VEC_W-1:0]        res;
        logic [c_VEC_W-1:0]        sd;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      rw;
        logic                      mw;
        logic                      mr;
        logic [LANES-1:0]          zm;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vector_ex_mem_buffer_if #(
        .DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) bus ();

    vector_ex_mem_buffer #(
        .DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    ent_t        mq[$];
    logic [15:0] mRet  = 16'd0;
    bit          monEn = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LANES-1:0] zeroOf(input logic [c_VEC_W-1:0] v);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++)
            m[i] = (((v >> (i * DATA_WIDTH)) & 48'hFF) == 48'h0);
        return m;
    endfunction

    // Reference model: a plain queue of at most two accepted entries.
    always @(posedge clk) begin
        bit   doPop;
        bit   doPush;
        ent_t e;
        if (!rst) begin
            mq.delete();
            mRet  = 16'd0;
            monEn = 1'b1;
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            doPop  = (mq.size() > 0) && bus.out_ready;
            doPush = bus.in_valid && (mq.size() < 2);
            e.res = bus.alu_result;
            e.sd  = bus.store_data;
            e.rd  = bus.rd;
            e.rw  = bus.reg_write;
            e.mw  = bus.mem_write;
            e.mr  = bus.mem_read;
            e.zm  = zeroOf(bus.alu_result);
            if (doPop) begin
                void'(mq.pop_front());
                mRet = mRet + 16'd1;
            end
            if (doPush) mq.push_back(e);
        end
    end

    // Monitor: compares outputs against the model head every cycle.
    always @(posedge clk) begin
        #2;
        if (monEn) begin
            chk("mon_in_ready", 64'(bus.in_ready), 64'(rst && mq.size() < 2));
            chk("mon_occupancy", 64'(bus.occupancy), 64'(mq.size()));
            chk("mon_retired", 64'(bus.retired_count), 64'(mRet));
            chk("mon_out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("mon_result", 64'(bus.out_result), 64'(mq[0].res));
                chk("mon_store", 64'(bus.out_store_data), 64'(mq[0].sd));
                chk("mon_ctrl", 64'({bus.out_rd, bus.out_reg_write, bus.out_mem_write, bus.out_mem_read}),
                    64'({mq[0].rd, mq[0].rw, mq[0].mw, mq[0].mr}));
                chk("mon_zmask", 64'(bus.out_zero_mask), 64'(mq[0].zm));
            end else begin
                chk("mon_idle_zero", 64'(bus.out_result | bus.out_store_data),  64'd0);
                chk("mon_idle_ctrl", 64'({bus.out_rd, bus.out_reg_write, bus.out_mem_write,
                    bus.out_mem_read, bus.out_zero_mask}), 64'd0);
            end
        end
    end

    function automatic logic [c_VEC_W-1:0] rndVec();
        logic [c_VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*DATA_WIDTH +: DATA_WIDTH] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        return v;
    endfunction

    task automatic rndEntry();
        bus.alu_result = rndVec();
        bus.store_data = rndVec();
        bus.rd         = 4'($urandom);
        bus.reg_write  = 1'($urandom);
        bus.mem_write  = 1'($urandom);
        bus.mem_read   = 1'($urandom);
    endtask

    task automatic waitSample();
        @(posedge clk);
        #3;
    endtask

    logic [c_VEC_W-1:0] valA;
    int                 guard;

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        rndEntry();

        // Reset held for two cycles with in_valid asserted
        waitSample();
        waitSample();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_retired", 64'(bus.retired_count), 64'd0);
        @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0;
        #1 chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        waitSample();

        // Single entry
        @(negedge clk);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.alu_result = 48'h00_05_00_FF_00_01; bus.store_data = 48'h0;
        bus.rd = 4'd3; bus.reg_write = 1'b1; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
        waitSample();
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_result", 64'(bus.out_result), 64'h0000_0005_00FF_0001);
        chk("single_rd", 64'(bus.out_rd), 64'd3);
        chk("single_zmask", 64'(bus.out_zero_mask), 64'b101010);
        @(negedge clk); bus.in_valid = 1'b0;
        waitSample();
        chk("single_retired", 64'(bus.retired_count), 64'd1);

        // Fill with out_ready low, then drain
        @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = 1'b1; rndEntry(); valA = bus.alu_result;
        waitSample();
        @(negedge clk); rndEntry();
        waitSample();
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_head_A", 64'(bus.out_result), 64'(valA));
        @(negedge clk); rndEntry();
        waitSample();
        chk("fill_occ", 64'(bus.occupancy), 64'd2);
        chk("fill_hold_A", 64'(bus.out_result), 64'(valA));
        @(negedge clk); bus.out_ready = 1'b1;
        waitSample();
        waitSample();
        @(negedge clk); bus.in_valid = 1'b0;
        waitSample();
        chk("fill_retired", 64'(bus.retired_count), 64'd4);
        chk("fill_empty", 64'(bus.out_valid), 64'd0);

        // Streaming: push and pop every cycle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.in_valid = 1'b1; rndEntry();
            waitSample();
            chk("stream_occ", 64'(bus.occupancy), 64'd1);
        end
        @(negedge clk); bus.in_valid = 1'b0;
        waitSample();

        // Flush with two entries held
        @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = 1'b1; rndEntry(); bus.mem_write = 1'b1;
        waitSample();
        @(negedge clk); rndEntry(); bus.mem_write = 1'b1;
        waitSample();
        @(negedge clk); bus.flush = 1'b1; bus.out_ready = 1'b1; rndEntry();
        #1 chk("flush_no_pop_ready", 64'(bus.in_ready), 64'd0);
        waitSample();
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_memw", 64'(bus.out_mem_write), 64'd0);
        chk("flush_retired", 64'(bus.retired_count), 64'd14);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk); bus.flush = 1'b0; bus.in_valid = 1'b0;

        // Randomised traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rndEntry();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            rst           = (i != 200);
        end
        @(negedge clk); rst = 1'b1; bus.flush = 1'b0;

        // Stream until the retired counter reaches 0xFFFF, then one more pop
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        guard = 0;
        while (mRet != 16'hFFFF && guard < 70000) begin
            waitSample();
            guard++;
        end
        chk("wrap_reached", 64'(mRet == 16'hFFFF), 64'd1);
        chk("wrap_pre", 64'(bus.retired_count), 64'hFFFF);
        waitSample();
        chk("wrap_zero", 64'(bus.retired_count), 64'h0000);

        // Reset mid-operation with entries held
        @(negedge clk); bus.out_ready = 1'b0;
        waitSample();
        @(negedge clk); rst = 1'b0;
        waitSample();
        chk("midrst_occ", 64'(bus.occupancy), 64'd0);
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_retired", 64'(bus.retired_count), 64'd0);
        @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0;
        waitSample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
